// File: rtl/astropix_asic_model_frame_engine_if.sv
// -----------------------------------------------------------------------------
// astropix_asic_model_frame_engine_if
// Egress bundle between the frame engine and the per-lane SPI egress shifters.
//   egress_rd    : per-lane pop strobe (consumer -> engine)
//   egress_data  : per-lane FIFO head byte, lane n at [8n+7:8n] (engine -> consumer)
//   egress_empty : per-lane empty flag (engine -> consumer)
// Modports: master = frame engine side, slave = egress consumer side.
// -----------------------------------------------------------------------------
interface astropix_asic_model_frame_engine_if #(
    parameter int LANES = 2
);
    logic [LANES-1:0]   egress_rd;
    logic [8*LANES-1:0] egress_data;
    logic [LANES-1:0]   egress_empty;

    modport master (
        input  egress_rd,
        output egress_data,
        output egress_empty
    );

    modport slave (
        output egress_rd,
        input  egress_data,
        input  egress_empty
    );
endinterface

// File: rtl/astropix_asic_model_frame_engine.sv
// -----------------------------------------------------------------------------
// astropix_asic_model_frame_engine
// Generates synthetic hit frames and spreads them round-robin over LANES
// per-lane byte FIFOs. Frames are written atomically or dropped whole when the
// target lane lacks room. Programmable inter-frame gap and level/pulse IRQ.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   gen_ctrl_frame_count    : frames per run (0 = unlimited)
//   gen_ctrl_frame_enable   : run enable, rising edge starts a run
//   gen_ctrl_interval       : idle cycles between frames
//   cfg_irq_pulse           : 0 = level interrupt, 1 = pulse interrupt
//   egress (master)         : per-lane pop / FWFT head byte / empty flag
//   interruptn              : active-low interrupt
//   busy                    : run in progress
//   frames_sent/dropped     : per-run saturating frame counters
// -----------------------------------------------------------------------------
module astropix_asic_model_frame_engine #(
    parameter int LANES        = 2,
    parameter int FIFO_DEPTH   = 64,
    parameter int FRAME_BYTES  = 5,
    parameter int IDLE_GAP_MIN = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [15:0]                                gen_ctrl_frame_count,
    input  logic                                       gen_ctrl_frame_enable,
    input  logic [15:0]                                gen_ctrl_interval,
    input  logic                                       cfg_irq_pulse,
    astropix_asic_model_frame_engine_if.master         egress,
    output logic                                       interruptn,
    output logic                                       busy,
    output logic [15:0]                                frames_sent,
    output logic [15:0]                                frames_dropped
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int FW = OW + 1;
    localparam logic [15:0] GAP_MIN = 16'(IDLE_GAP_MIN);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_CHECK, S_WRITE, S_NEXT} state_t;

    state_t          state_q, state_d;
    logic            en_prev_q;
    logic [15:0]     gap_cnt_q, gap_cnt_d;
    logic [3:0]      byte_idx_q, byte_idx_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     sent_q, sent_d;
    logic [15:0]     dropped_q, dropped_d;
    logic            irqn_level_q, irqn_level_d;
    logic            irqn_pulse_q, irqn_pulse_d;

    // Per-lane FIFO state
    logic [LANES-1:0][OW-1:0] occ_q, occ_d;
    logic [LANES-1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LANES-1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LANES-1:0]         lane_push, lane_pop;
    logic [7:0]               fifo_mem [LANES][FIFO_DEPTH];

    logic            push;
    logic [7:0]      push_byte;
    logic [1:0]      lane2;
    logic [15:0]     gap_len;
    logic [FW-1:0]   free_space;
    logic            run_done;
    logic            all_empty_next;

    assign lane2      = 2'(lane_q);
    assign gap_len    = (gen_ctrl_interval < GAP_MIN) ? GAP_MIN : gen_ctrl_interval;
    assign free_space = FW'(FIFO_DEPTH) - FW'(occ_q[lane_q]);
    assign run_done   = (gen_ctrl_frame_count != 16'd0) &&
                        ((17'(sent_q) + 17'(dropped_q)) == 17'(gen_ctrl_frame_count));
    assign push_byte  = (byte_idx_q == 4'd0) ? {2'b10, lane2, seq_q[3:0]}
                                             : seq_q + 8'(byte_idx_q);

    // Frame sequencer
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = '0;
        byte_idx_d = '0;
        lane_d     = lane_q;
        seq_d      = seq_q;
        sent_d     = sent_q;
        dropped_d  = dropped_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gen_ctrl_frame_enable && !en_prev_q) begin
                    sent_d    = '0;
                    dropped_d = '0;
                    seq_d     = '0;
                    lane_d    = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (!gen_ctrl_frame_enable) begin
                    state_d = S_IDLE;
                end else if ((17'(gap_cnt_q) + 17'd1) >= 17'(gap_len)) begin
                    state_d = S_CHECK;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                if (!gen_ctrl_frame_enable) begin
                    state_d = S_IDLE;
                end else if (free_space >= FW'(FRAME_BYTES)) begin
                    state_d = S_WRITE;
                end else begin
                    // Whole frame is dropped; nothing is written to the lane.
                    if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
                    state_d = S_NEXT;
                end
            end
            S_WRITE: begin
                // Enable is ignored here so a started frame always completes.
                push = 1'b1;
                if (byte_idx_q == 4'(FRAME_BYTES - 1)) begin
                    if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
                    state_d = S_NEXT;
                end else begin
                    byte_idx_d = byte_idx_q + 4'd1;
                end
            end
            S_NEXT: begin
                lane_d = (lane_q == LW'(LANES - 1)) ? '0 : lane_q + LW'(1);
                seq_d  = seq_q + 8'd1;
                if (!gen_ctrl_frame_enable || run_done) state_d = S_IDLE;
                else                                    state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer / occupancy update; simultaneous push+pop cancels out.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_push[l] = push && (lane_q == LW'(l));
            lane_pop[l]  = egress.egress_rd[l] && (occ_q[l] != '0);
            wr_ptr_d[l]  = wr_ptr_q[l] + AW'(lane_push[l]);
            rd_ptr_d[l]  = rd_ptr_q[l] + AW'(lane_pop[l]);
            occ_d[l]     = occ_q[l] + OW'(lane_push[l]) - OW'(lane_pop[l]);
        end
    end

    // Interrupt generation. Level: asserted by the first byte of a frame,
    // released once every lane will be empty; a push always wins.
    // Pulse: one low cycle following the last byte of each frame.
    always_comb begin
        all_empty_next = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (occ_d[l] != '0) all_empty_next = 1'b0;
        end
        irqn_level_d = irqn_level_q;
        if (push && (byte_idx_q == 4'd0))   irqn_level_d = 1'b0;
        else if (!push && all_empty_next)   irqn_level_d = 1'b1;
        irqn_pulse_d = !(push && (byte_idx_q == 4'(FRAME_BYTES - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            en_prev_q    <= 1'b0;
            gap_cnt_q    <= '0;
            byte_idx_q   <= '0;
            lane_q       <= '0;
            seq_q        <= '0;
            sent_q       <= '0;
            dropped_q    <= '0;
            irqn_level_q <= 1'b1;
            irqn_pulse_q <= 1'b1;
            occ_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            en_prev_q    <= gen_ctrl_frame_enable;
            gap_cnt_q    <= gap_cnt_d;
            byte_idx_q   <= byte_idx_d;
            lane_q       <= lane_d;
            seq_q        <= seq_d;
            sent_q       <= sent_d;
            dropped_q    <= dropped_d;
            irqn_level_q <= irqn_level_d;
            irqn_pulse_q <= irqn_pulse_d;
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage is not reset; reset empties the FIFOs through the pointers.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_push[l]) fifo_mem[l][wr_ptr_q[l]] <= push_byte;
        end
    end

    // First-word-fall-through head: the head byte must be visible in the same
    // cycle it becomes valid, so the read side is combinational. An empty lane
    // presents 0 so stale storage never leaks out.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign egress.egress_empty[gi]        = (occ_q[gi] == '0);
            assign egress.egress_data[8*gi +: 8]  = (occ_q[gi] == '0) ? 8'h00
                                                   : fifo_mem[gi][rd_ptr_q[gi]];
        end
    endgenerate

    assign busy           = (state_q != S_IDLE);
    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;
    assign interruptn     = cfg_irq_pulse ? irqn_pulse_q : irqn_level_q;

endmodule

// File: tb/tb_astropix_asic_model_frame_engine.sv
// -----------------------------------------------------------------------------
// tb_astropix_asic_model_frame_engine
// Directed + randomized bench. Expected lane contents and counters come from a
// frame-level model (frame i -> lane i mod LANES, seq i mod 256, kept only if
// the lane still has room for a whole frame); gap timing comes from the state
// sequence WRITE(FRAME_BYTES) + NEXT + GAP(max(interval,min)) + CHECK.
// -----------------------------------------------------------------------------
module tb_astropix_asic_model_frame_engine;
    localparam int L    = 2;
    localparam int D    = 64;
    localparam int FB   = 5;
    localparam int GMIN = 1;
    localparam logic [L-1:0] ALL1 = '1;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cnt = '0;
    logic        en = 1'b0;
    logic [15:0] interval = '0;
    logic        pulse = 1'b0;
    logic        interruptn, busy;
    logic [15:0] sent, dropped;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    bit   reader_on = 1'b0;
    rec_t cap[$];
    rec_t exp_q[$];
    int   exp_sent, exp_drop;
    int   low_times[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    astropix_asic_model_frame_engine_if #(.LANES(L)) eg ();

    astropix_asic_model_frame_engine #(
        .LANES(L), .FIFO_DEPTH(D), .FRAME_BYTES(FB), .IDLE_GAP_MIN(GMIN)
    ) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .gen_ctrl_frame_count  (cnt),
        .gen_ctrl_frame_enable (en),
        .gen_ctrl_interval     (interval),
        .cfg_irq_pulse         (pulse),
        .egress                (eg),
        .interruptn            (interruptn),
        .busy                  (busy),
        .frames_sent           (sent),
        .frames_dropped        (dropped)
    );

    // Background consumer: pops every non-empty lane each cycle while enabled
    // and records the head byte that the next edge consumes.
    initial begin
        eg.egress_rd = '0;
        forever begin
            @(negedge clk);
            if (reader_on) begin
                for (int l = 0; l < L; l++) begin
                    if (!eg.egress_empty[l]) cap.push_back({2'(l), eg.egress_data[8*l +: 8]});
                end
                eg.egress_rd = ~eg.egress_empty;
            end else begin
                eg.egress_rd = '0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Frame-level reference: which frames land where, and what bytes they carry.
    task automatic model_run(input int count, input bit unlimited);
        int occ[4];
        int lane, seq;
        logic [7:0] b;
        exp_q.delete();
        exp_sent = 0;
        exp_drop = 0;
        for (int l = 0; l < 4; l++) occ[l] = 0;
        for (int i = 0; i < count; i++) begin
            lane = i % L;
            seq  = i % 256;
            if (unlimited || (occ[lane] + FB <= D)) begin
                occ[lane] += FB;
                exp_sent++;
                for (int k = 0; k < FB; k++) begin
                    if (k == 0) b = 8'(128 + lane * 16 + (seq % 16));
                    else        b = 8'((seq + k) % 256);
                    exp_q.push_back({2'(lane), b});
                end
            end else begin
                exp_drop++;
            end
        end
    endtask

    task automatic compare_lanes(input string tag);
        logic [7:0] g[$];
        logic [7:0] e[$];
        int bad;
        for (int l = 0; l < L; l++) begin
            g.delete();
            e.delete();
            foreach (cap[i])   if (cap[i].lane == 2'(l))   g.push_back(cap[i].data);
            foreach (exp_q[i]) if (exp_q[i].lane == 2'(l)) e.push_back(exp_q[i].data);
            check($sformatf("%s lane%0d len", tag, l), 32'(g.size()), 32'(e.size()));
            bad = -1;
            for (int i = 0; i < g.size() && i < e.size(); i++) begin
                if (bad < 0 && g[i] !== e[i]) bad = i;
            end
            check($sformatf("%s lane%0d first_bad_idx", tag, l), 32'(bad), 32'hFFFF_FFFF);
        end
    endtask

    task automatic start_run(input int count, input int iv, input bit pm);
        @(negedge clk);
        cnt      = 16'(count);
        interval = 16'(iv);
        pulse    = pm;
        en       = 1'b1;
    endtask

    task automatic end_run();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Waits for busy to fall, logging the cycles where interruptn was low.
    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        low_times.delete();
        @(negedge clk);
        if (interruptn === 1'b0) low_times.push_back(cyc);
        while (busy === 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
            if (interruptn === 1'b0) low_times.push_back(cyc);
        end
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string tag);
        int quiet, c;
        quiet = 0;
        c = 0;
        reader_on = 1'b1;
        while (quiet < 3 && c < 3000) begin
            @(negedge clk);
            c++;
            if (eg.egress_empty == ALL1) quiet++;
            else quiet = 0;
        end
        reader_on = 1'b0;
        @(negedge clk);
        check({tag, " drained"}, 32'(eg.egress_empty), 32'(ALL1));
    endtask

    task automatic wait_fall(input string tag, input int l, input int budget);
        logic prev;
        int c;
        bit ok;
        c = 0;
        ok = 1'b0;
        prev = eg.egress_empty[l];
        while (!ok && c < budget) begin
            @(negedge clk);
            c++;
            if (prev === 1'b1 && eg.egress_empty[l] === 1'b0) ok = 1'b1;
            prev = eg.egress_empty[l];
        end
        check({tag, " first push seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        int c_iv, c_cnt, lcnt, gap_eff;
        bit pm, got;
        logic prev_irq;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst interruptn", 32'(interruptn), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sent", 32'(sent), 32'd0);
        check("rst dropped", 32'(dropped), 32'd0);
        check("rst empty", 32'(eg.egress_empty), 32'(ALL1));
        check("rst data", 32'(eg.egress_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- basic 4-frame run ----------------
        cap.delete();
        start_run(4, 0, 1'b0);
        wait_idle("basic", 400);
        model_run(4, 1'b0);
        check("basic sent", 32'(sent), 32'(exp_sent));
        check("basic dropped", 32'(dropped), 32'(exp_drop));
        check("basic lane0 head", 32'(eg.egress_data[7:0]), 32'h80);
        check("basic lane1 head", 32'(eg.egress_data[15:8]), 32'h91);
        check("basic level irq asserted", 32'(interruptn), 32'd0);
        drain("basic");
        compare_lanes("basic");
        check("basic level irq released", 32'(interruptn), 32'd1);
        end_run();

        // ---------------- drop-on-full ----------------
        cap.delete();
        c_iv = $urandom_range(0, 3);
        start_run(30, c_iv, 1'b0);
        wait_idle("drop", 2000);
        model_run(30, 1'b0);
        check("drop sent", 32'(sent), 32'(exp_sent));
        check("drop dropped", 32'(dropped), 32'(exp_drop));
        drain("drop");
        compare_lanes("drop");
        end_run();

        // ---------------- randomized runs ----------------
        for (int it = 0; it < 6; it++) begin
            cap.delete();
            c_cnt = $urandom_range(1, 40);
            c_iv  = $urandom_range(0, 4);
            pm    = 1'($urandom_range(0, 1));
            start_run(c_cnt, c_iv, pm);
            wait_idle($sformatf("rnd%0d", it), 3000);
            model_run(c_cnt, 1'b0);
            check($sformatf("rnd%0d sent", it), 32'(sent), 32'(exp_sent));
            check($sformatf("rnd%0d dropped", it), 32'(dropped), 32'(exp_drop));
            if (pm) check($sformatf("rnd%0d pulse count", it), 32'(low_times.size()), 32'(exp_sent));
            else    check($sformatf("rnd%0d level irq", it), 32'(interruptn), 32'd0);
            drain($sformatf("rnd%0d", it));
            compare_lanes($sformatf("rnd%0d", it));
            end_run();
        end

        // ---------------- level interrupt timing ----------------
        cap.delete();
        start_run(1, 0, 1'b0);
        prev_irq = interruptn;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (eg.egress_empty[0] === 1'b0) got = 1'b1;
            else prev_irq = interruptn;
        end
        check("lvl push seen", 32'(got), 32'd1);
        check("lvl high before push", 32'(prev_irq), 32'd1);
        check("lvl low after push", 32'(interruptn), 32'd0);
        wait_idle("lvl", 100);
        reader_on = 1'b1;
        got = 1'b0;
        prev_irq = interruptn;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (eg.egress_empty == ALL1) got = 1'b1;
            else prev_irq = interruptn;
        end
        reader_on = 1'b0;
        check("lvl all empty seen", 32'(got), 32'd1);
        check("lvl low until last pop", 32'(prev_irq), 32'd0);
        check("lvl high after last pop", 32'(interruptn), 32'd1);
        end_run();

        // ---------------- pulse width / inter-frame spacing ----------------
        for (int pass = 0; pass < 2; pass++) begin
            cap.delete();
            c_iv = (pass == 0) ? 10 : 0;
            gap_eff = (c_iv < GMIN) ? GMIN : c_iv;
            reader_on = 1'b1;
            start_run(3, c_iv, 1'b1);
            wait_idle($sformatf("pulse iv%0d", c_iv), 400);
            lcnt = low_times.size();
            check($sformatf("pulse iv%0d low cycles", c_iv), 32'(lcnt), 32'd3);
            if (lcnt == 3) begin
                check($sformatf("pulse iv%0d spacing01", c_iv),
                      32'(low_times[1] - low_times[0]), 32'(FB + gap_eff + 2));
                check($sformatf("pulse iv%0d spacing12", c_iv),
                      32'(low_times[2] - low_times[1]), 32'(FB + gap_eff + 2));
            end
            reader_on = 1'b0;
            drain($sformatf("pulse iv%0d", c_iv));
            end_run();
        end

        // ---------------- unlimited run, seq wrap, enable drop mid-WRITE ----------------
        cap.delete();
        reader_on = 1'b1;
        start_run(0, 0, 1'b0);
        repeat (2800) @(negedge clk);
        wait_fall("long", 0, 100);
        en = 1'b0;
        wait_idle("long", 100);
        check("long wrapped past 255", 32'(sent > 16'd256), 32'd1);
        check("long dropped", 32'(dropped), 32'd0);
        reader_on = 1'b0;
        drain("long");
        check("long whole frames", 32'(cap.size()), 32'(FB) * 32'(sent));
        model_run(int'(sent), 1'b1);
        compare_lanes("long");
        end_run();

        // ---------------- reset during WRITE, then restart ----------------
        cap.delete();
        start_run(10, 0, 1'b0);
        wait_fall("rstw", 1, 200);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check("rstw interruptn", 32'(interruptn), 32'd1);
        check("rstw empty", 32'(eg.egress_empty), 32'(ALL1));
        check("rstw sent", 32'(sent), 32'd0);
        check("rstw dropped", 32'(dropped), 32'd0);
        check("rstw busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_run(1, 0, 1'b0);
        wait_idle("restart", 100);
        check("restart lane0 head", 32'(eg.egress_data[7:0]), 32'h80);
        check("restart empty", 32'(eg.egress_empty), 32'h2);
        check("restart sent", 32'(sent), 32'd1);
        model_run(1, 1'b0);
        drain("restart");
        compare_lanes("restart");
        end_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
